// File: rtl/triangle_edge_fetcher.sv
// Pops projected triangles from the triangle FIFO and streams their three edges to the line rasterizer.
// Build option CULL_DEGENERATE_EN: drop zero-area triangles in a one-cycle CULL state and count them.
module triangle_edge_fetcher #(
  parameter int FIFO_RD_LAT = 1,
  parameter int CNT_W       = 8
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   draw_start,
  input  logic                   fifo_empty,
  input  logic [2:0][1:0][9:0]   triangle_in,
  output logic                   fifo_r,
  output logic                   edge_valid,
  input  logic                   edge_ready,
  output logic [9:0]             edge_x0,
  output logic [9:0]             edge_y0,
  output logic [9:0]             edge_x1,
  output logic [9:0]             edge_y1,
  output logic                   busy,
  output logic                   draw_done,
  output logic [CNT_W-1:0]       tri_count
`ifdef CULL_DEGENERATE_EN
  ,
  output logic [CNT_W-1:0]       cull_count
`endif
);

`ifdef CULL_DEGENERATE_EN
  typedef enum logic [3:0] {IDLE, CHECK, POP, WAIT, E0, E1, E2, DONE, CULL} state_t;
`else
  typedef enum logic [2:0] {IDLE, CHECK, POP, WAIT, E0, E1, E2, DONE} state_t;
`endif

  state_t                 state, state_nxt;
  logic [2:0][1:0][9:0]   vtx;
  logic                   latch, edge_ld, accept;
  logic [39:0]            e_nxt;

  function automatic logic [39:0] seg(input logic [1:0][9:0] a, input logic [1:0][9:0] b);
    return {a[0], a[1], b[0], b[1]};
  endfunction

`ifdef CULL_DEGENERATE_EN
  logic signed [10:0] dx1, dy1, dx2, dy2;
  logic signed [21:0] p0, p1, cross;
  logic               degen;

  always_comb begin
    dx1   = $signed({1'b0, vtx[1][0]}) - $signed({1'b0, vtx[0][0]});
    dy1   = $signed({1'b0, vtx[1][1]}) - $signed({1'b0, vtx[0][1]});
    dx2   = $signed({1'b0, vtx[2][0]}) - $signed({1'b0, vtx[0][0]});
    dy2   = $signed({1'b0, vtx[2][1]}) - $signed({1'b0, vtx[0][1]});
    p0    = 22'(dx1) * 22'(dy2);
    p1    = 22'(dx2) * 22'(dy1);
    // |p0 - p1| <= 2*1023^2, which still fits the 22-bit signed range
    cross = p0 - p1;
    degen = (cross == 22'sd0);
  end
`endif

  // Reset gates the strobes so nothing is popped or handed off during the reset cycle itself.
  assign fifo_r     = (state == POP) && Reset_n;
  assign edge_valid = ((state == E0) || (state == E1) || (state == E2)) && Reset_n;
  assign busy       = (state != IDLE) && (state != DONE);
  assign draw_done  = (state == DONE);
  assign accept     = edge_valid && edge_ready;

  always_comb begin
    state_nxt = state;
    latch     = 1'b0;
    edge_ld   = 1'b0;
    e_nxt     = '0;
    case (state)
      IDLE:  if (draw_start) state_nxt = CHECK;
      CHECK: state_nxt = fifo_empty ? DONE : POP;
      POP: begin
        if (FIFO_RD_LAT == 0) latch = 1'b1;
        else                  state_nxt = WAIT;
      end
      WAIT:  latch = 1'b1;
      E0: if (accept) begin
        state_nxt = E1;
        edge_ld   = 1'b1;
        e_nxt     = seg(vtx[1], vtx[2]);
      end
      E1: if (accept) begin
        state_nxt = E2;
        edge_ld   = 1'b1;
        e_nxt     = seg(vtx[2], vtx[0]);
      end
      E2:    if (accept) state_nxt = CHECK;
      DONE:  state_nxt = IDLE;
`ifdef CULL_DEGENERATE_EN
      CULL: begin
        if (degen) state_nxt = CHECK;
        else begin
          state_nxt = E0;
          edge_ld   = 1'b1;
          e_nxt     = seg(vtx[0], vtx[1]);
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (latch) begin
`ifdef CULL_DEGENERATE_EN
      state_nxt = CULL;
`else
      // First edge comes straight from the FIFO head so E0 is valid the cycle after the latch.
      state_nxt = E0;
      edge_ld   = 1'b1;
      e_nxt     = seg(triangle_in[0], triangle_in[1]);
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state     <= IDLE;
      vtx       <= '0;
      edge_x0   <= '0;
      edge_y0   <= '0;
      edge_x1   <= '0;
      edge_y1   <= '0;
      tri_count <= '0;
    end else begin
      state <= state_nxt;
      if (latch)   vtx <= triangle_in;
      if (edge_ld) {edge_x0, edge_y0, edge_x1, edge_y1} <= e_nxt;
      if (state == IDLE && draw_start)             tri_count <= '0;
      else if (state == POP && tri_count != '1)    tri_count <= tri_count + 1'b1;
    end
  end

`ifdef CULL_DEGENERATE_EN
  always_ff @(posedge Clk) begin
    if (!Reset_n)                                          cull_count <= '0;
    else if (state == IDLE && draw_start)                  cull_count <= '0;
    else if (state == CULL && degen && cull_count != '1)   cull_count <= cull_count + 1'b1;
  end
`endif

endmodule

// File: tb/tb_triangle_edge_fetcher.sv
// Bench for triangle_edge_fetcher: queue-based FIFO and edge-order reference model, registered-read FIFO.
module tb_triangle_edge_fetcher;
  localparam int CNT_W = 8;
  typedef logic [2:0][1:0][9:0] tri_t;

  logic               Clk = 1'b0;
  logic               Reset_n = 1'b0;
  logic               draw_start = 1'b0;
  logic               fifo_empty = 1'b1;
  logic               edge_ready = 1'b0;
  tri_t               triangle_in = '0;
  logic               fifo_r, edge_valid, busy, draw_done;
  logic [9:0]         edge_x0, edge_y0, edge_x1, edge_y1;
  logic [CNT_W-1:0]   tri_count;
`ifdef CULL_DEGENERATE_EN
  logic [CNT_W-1:0]   cull_count;
`endif

  int tests = 0;
  int fails = 0;

  always #10 Clk = ~Clk;

  triangle_edge_fetcher #(.FIFO_RD_LAT(1), .CNT_W(CNT_W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .draw_start(draw_start), .fifo_empty(fifo_empty),
    .triangle_in(triangle_in), .fifo_r(fifo_r), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .edge_x0(edge_x0), .edge_y0(edge_y0), .edge_x1(edge_x1), .edge_y1(edge_y1),
    .busy(busy), .draw_done(draw_done), .tri_count(tri_count)
`ifdef CULL_DEGENERATE_EN
    , .cull_count(cull_count)
`endif
  );

  tri_t        fq[$];
  logic [39:0] eq[$];
  int          acc_cyc[$];
  int          rdy_mode = 2;
  bit          pop_pend = 0;
  bit          hold = 0;
  logic [39:0] held = '0;
  int          n_pops = 0, n_acc = 0, n_done = 0, cyc_n = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic tri_t mk(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2);
    tri_t t;
    t[0][0] = 10'(x0); t[0][1] = 10'(y0);
    t[1][0] = 10'(x1); t[1][1] = 10'(y1);
    t[2][0] = 10'(x2); t[2][1] = 10'(y2);
    return t;
  endfunction

  // A triangle becomes edges v0->v1, v1->v2, v2->v0 in that order.
  task automatic push(input tri_t t);
    fq.push_back(t);
    for (int k = 0; k < 3; k++) begin
      int kk = (k + 1) % 3;
      eq.push_back({t[k][0], t[k][1], t[kk][0], t[kk][1]});
    end
  endtask

  function automatic tri_t rnd_tri();
    tri_t t;
    for (int v = 0; v < 3; v++)
      for (int c = 0; c < 2; c++) t[v][c] = 10'($urandom_range(0, 1023));
    return t;
  endfunction

  // One clock: inputs change 1 time unit after the edge, outputs are sampled on the falling edge.
  task automatic cyc();
    @(posedge Clk); #1;
    draw_start = 1'b0;
    if (pop_pend) begin
      if (fq.size() > 0) triangle_in = fq.pop_front();
      pop_pend = 0;
    end
    fifo_empty = (fq.size() == 0);
    case (rdy_mode)
      0:       edge_ready = 1'b1;
      1:       edge_ready = 1'($urandom_range(0, 1));
      default: edge_ready = 1'b0;
    endcase
    @(negedge Clk);
    cyc_n++;
    if (hold && Reset_n) begin
      check("stall_valid", edge_valid, 1);
      check("stall_hold", {edge_x0, edge_y0, edge_x1, edge_y1}, held);
    end
    hold = edge_valid && !edge_ready && Reset_n;
    held = {edge_x0, edge_y0, edge_x1, edge_y1};
    if (fifo_r) begin
      check("pop_nonempty", fifo_empty, 0);
      n_pops++;
      pop_pend = 1;
    end
    if (edge_valid && edge_ready) begin
      if (eq.size() > 0) check("edge", {edge_x0, edge_y0, edge_x1, edge_y1}, eq.pop_front());
      else               check("edge_extra", edge_valid, 0);
      n_acc++;
      acc_cyc.push_back(cyc_n);
    end
    if (draw_done) n_done++;
  endtask

  task automatic run(input int maxc, input int repulse, output int lat);
    int st;
    lat = -1;
    n_done = 0;
    draw_start = 1'b1;
    st = cyc_n;
    for (int c = 0; c < maxc; c++) begin
      if (c == repulse) draw_start = 1'b1;
      cyc();
      if (c == 0) check("busy_after_start", busy, 1);
      if (draw_done) begin
        lat = cyc_n - st;
        check("busy_at_done", busy, 0);
        break;
      end
    end
    check("done_seen", lat > 0, 1);
  endtask

  initial begin
    int lat;
    tri_t t;

    // Reset state
    Reset_n = 1'b0;
    cyc(); cyc();
    check("rst_fifo_r", fifo_r, 0);
    check("rst_valid", edge_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", draw_done, 0);
    check("rst_count", tri_count, 0);
    check("rst_edges", {edge_x0, edge_y0, edge_x1, edge_y1}, 0);
    Reset_n = 1'b1;
    cyc();

    // Empty FIFO: done two cycles after the start pulse, no pops
    n_pops = 0;
    run(20, -1, lat);
    check("empty_latency", lat, 2);
    check("empty_pops", n_pops, 0);
    check("empty_count", tri_count, 0);

    // Single triangle, ready held high
    push(mk(10, 20, 100, 20, 50, 90));
    check("tri1_e0_model", eq[0], {10'd10, 10'd20, 10'd100, 10'd20});
    rdy_mode = 0;
    cyc();
    n_pops = 0; n_acc = 0; acc_cyc.delete();
    run(50, -1, lat);
    check("one_latency", lat, 8);
    check("one_pops", n_pops, 1);
    check("one_count", tri_count, 1);
    check("one_edges", n_acc, 3);
    check("one_left", eq.size(), 0);
    if (acc_cyc.size() == 3) begin
      check("one_back2back_a", acc_cyc[1] - acc_cyc[0], 1);
      check("one_back2back_b", acc_cyc[2] - acc_cyc[1], 1);
    end

    // Three random triangles, random ready, restart pulse while busy
    for (int i = 0; i < 3; i++) push(rnd_tri());
    rdy_mode = 1;
    cyc();
    n_pops = 0; n_acc = 0;
    run(400, 5, lat);
    for (int i = 0; i < 6; i++) cyc();
    check("rand_single_done", n_done, 1);
    check("rand_pops", n_pops, 3);
    check("rand_count", tri_count, 3);
    check("rand_edges", n_acc, 9);
    check("rand_left", eq.size(), 0);
    check("rand_idle_busy", busy, 0);

    // Counter saturation
    for (int i = 0; i < 260; i++) push(rnd_tri());
    rdy_mode = 0;
    cyc();
    n_pops = 0; n_acc = 0;
    run(2000, -1, lat);
    check("sat_latency", lat, 6 * 260 + 2);
    check("sat_count", tri_count, 255);
    check("sat_pops", n_pops, 260);
    check("sat_left", eq.size(), 0);

    // Reset while E1 is stalled with valid high
    push(rnd_tri());
    push(rnd_tri());
    rdy_mode = 2;
    cyc();
    draw_start = 1'b1;
    for (int i = 0; i < 20 && !edge_valid; i++) cyc();
    check("mid_e0_valid", edge_valid, 1);
    rdy_mode = 0;
    cyc();
    rdy_mode = 2;
    cyc();
    check("mid_e1_valid", edge_valid, 1);
    if (eq.size() > 0) check("mid_e1_edge", {edge_x0, edge_y0, edge_x1, edge_y1}, eq[0]);
    Reset_n = 1'b0;
    cyc();
    check("mid_rst_valid", edge_valid, 0);
    check("mid_rst_fifo_r", fifo_r, 0);
    cyc();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_count", tri_count, 0);
    check("mid_rst_done", draw_done, 0);
    eq.delete(); fq.delete(); pop_pend = 0; hold = 0;
    Reset_n = 1'b1;
    n_pops = 0; n_acc = 0;
    for (int i = 0; i < 5; i++) cyc();
    check("post_rst_pops", n_pops, 0);
    check("post_rst_edges", n_acc, 0);
    run(20, -1, lat);
    check("post_rst_latency", lat, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
